// File: rtl/blt_cmd_queue.sv
// Command byte queue: decodes bytes from a UART receiver into command codes,
// buffers them in a small FIFO and issues them one at a time as one-hot,
// one-cycle pulses spaced by a fixed number of idle cycles.
//
// Handshake: rx_ack is a one-cycle strobe qualifying rx_data and there is no
// back-pressure. A valid byte is accepted on the rising edge that ends the
// rx_ack cycle if the FIFO has room or is popped on that same edge; otherwise
// it is counted as dropped. Outside rx_ack, rx_data is ignored.
module blt_cmd_queue #(
    parameter int         N_CMD     = 7,
    parameter logic [7:0] BASE_CHAR = 8'h31,
    parameter int         CODE_W    = 3,
    parameter int         DEPTH     = 4,
    parameter int         GAP       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ack,
    input  logic              enable,
    output logic [N_CMD-1:0]  cmd_pulse,
    output logic [CODE_W-1:0] cmd_code,
    output logic [N_CMD-1:0]  cmd_hold,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [7:0]        err_cnt,
    output logic [7:0]        drop_cnt,
    output logic [1:0]        dbg_state
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    // WAIT is entered with GAP-1 loaded so that it spans exactly GAP cycles.
    localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [CODE_W-1:0] mem [DEPTH];

    logic [7:0]        rx_code;
    logic              rx_valid;
    logic              pop;
    logic              push;
    logic [CODE_W-1:0] head;
    logic [N_CMD-1:0]  head_onehot;

    assign rx_code   = rx_data - BASE_CHAR;
    assign rx_valid  = rx_ack && (rx_data >= BASE_CHAR) && (rx_code < 8'(N_CMD));

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // The head is popped on the same edge the FSM leaves IDLE, so a push on
    // that edge may take the freed slot even when the FIFO is full.
    assign pop  = (state == IDLE) && enable && !fifo_empty;
    assign push = rx_valid && (!fifo_full || pop);
    assign head = mem[rd_ptr[AW-1:0]];

    assign dbg_state = state;

    // One-hot decode of the FIFO head.
    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < N_CMD; i++) begin
            head_onehot[i] = (head == CODE_W'(i));
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= rx_code[CODE_W-1:0];
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Saturating counters for out-of-range bytes and bytes lost to a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt  <= 8'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (rx_ack && !rx_valid && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (rx_valid && !push && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Issue FSM with registered pulse, code and hold outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            cmd_pulse <= '0;
            cmd_code  <= '0;
            cmd_hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= ISSUE;
                        cmd_pulse <= head_onehot;
                        cmd_code  <= head;
                        cmd_hold  <= head_onehot;
                    end
                end
                ISSUE: begin
                    cmd_pulse <= '0;
                    if (GAP > 0) begin
                        state    <= WAIT;
                        wait_cnt <= GAP_M1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_pulse <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blt_cmd_queue.sv
// Self-checking bench for blt_cmd_queue: directed scenarios plus a randomized
// phase, all compared against a queue-based behavioural model.
module tb_blt_cmd_queue;

    localparam int         N_CMD     = 7;
    localparam logic [7:0] BASE_CHAR = 8'h31;
    localparam int         CODE_W    = 3;
    localparam int         DEPTH     = 4;
    localparam int         GAP       = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // ---------------- DUT (default GAP) ----------------
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ack  = 1'b0;
    logic              enable  = 1'b0;
    logic [N_CMD-1:0]  cmd_pulse;
    logic [CODE_W-1:0] cmd_code;
    logic [N_CMD-1:0]  cmd_hold;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        err_cnt;
    logic [7:0]        drop_cnt;
    logic [1:0]        dbg_state;

    blt_cmd_queue #(
        .N_CMD(N_CMD), .BASE_CHAR(BASE_CHAR), .CODE_W(CODE_W),
        .DEPTH(DEPTH), .GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ack(rx_ack),
        .enable(enable), .cmd_pulse(cmd_pulse), .cmd_code(cmd_code),
        .cmd_hold(cmd_hold), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .err_cnt(err_cnt), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    // ---------------- DUT (GAP = 0 build) ----------------
    logic [7:0]        rx_data2 = 8'h00;
    logic              rx_ack2  = 1'b0;
    logic              enable2  = 1'b0;
    logic [N_CMD-1:0]  cmd_pulse2;
    logic [CODE_W-1:0] cmd_code2;
    logic [N_CMD-1:0]  cmd_hold2;
    logic              fifo_full2;
    logic              fifo_empty2;
    logic [7:0]        err_cnt2;
    logic [7:0]        drop_cnt2;
    logic [1:0]        dbg_state2;

    blt_cmd_queue #(
        .N_CMD(N_CMD), .BASE_CHAR(BASE_CHAR), .CODE_W(CODE_W),
        .DEPTH(DEPTH), .GAP(0)
    ) dut_g0 (
        .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_ack(rx_ack2),
        .enable(enable2), .cmd_pulse(cmd_pulse2), .cmd_code(cmd_code2),
        .cmd_hold(cmd_hold2), .fifo_full(fifo_full2), .fifo_empty(fifo_empty2),
        .err_cnt(err_cnt2), .drop_cnt(drop_cnt2), .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard / model ----------------
    int tests = 0;
    int fails = 0;

    logic [CODE_W-1:0] exp_q[$];      // queued command codes, oldest first
    int                m_busy = 0;    // cycles until the issuer may pop again
    logic [N_CMD-1:0]  m_pulse = '0;
    logic [CODE_W-1:0] m_code = '0;
    logic [N_CMD-1:0]  m_hold = '0;
    int                m_err = 0;
    int                m_drop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy  = 0;
        m_pulse = '0;
        m_code  = '0;
        m_hold  = '0;
        m_err   = 0;
        m_drop  = 0;
    endtask

    task automatic check_all();
        check("pulse", 32'(cmd_pulse), 32'(m_pulse));
        check("code",  32'(cmd_code),  32'(m_code));
        check("hold",  32'(cmd_hold),  32'(m_hold));
        check("full",  32'(fifo_full), 32'(exp_q.size() == DEPTH));
        check("empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
        check("err",   32'(err_cnt),   32'(m_err));
        check("drop",  32'(drop_cnt),  32'(m_drop));
    endtask

    // Advance one clock: update the model from the inputs presented this
    // cycle, then compare against the DUT just after the edge.
    task automatic cyc();
        logic [7:0]        c;
        logic [CODE_W-1:0] hc;
        bit                valid, pop, push;
        c     = rx_data - BASE_CHAR;
        valid = rx_ack && (rx_data >= BASE_CHAR) && (int'(c) < N_CMD);
        pop   = (m_busy == 0) && enable && (exp_q.size() > 0);
        push  = valid && ((exp_q.size() < DEPTH) || pop);
        if (pop) begin
            hc      = exp_q.pop_front();
            m_pulse = '0;
            m_pulse[hc] = 1'b1;
            m_code  = hc;
            m_hold  = m_pulse;
            m_busy  = GAP + 1;
        end else begin
            m_pulse = '0;
            if (m_busy > 0) m_busy--;
        end
        if (push) exp_q.push_back(c[CODE_W-1:0]);
        if (rx_ack && !valid && m_err < 255) m_err++;
        if (valid && !push && m_drop < 255) m_drop++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b);
        rx_ack  = 1'b1;
        rx_data = b;
        cyc();
        rx_ack  = 1'b0;
        rx_data = 8'($urandom_range(0, 255));   // must be ignored
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pulse"}, 32'(cmd_pulse), 32'd0);
        check({tag, "_code"},  32'(cmd_code),  32'd0);
        check({tag, "_hold"},  32'(cmd_hold),  32'd0);
        check({tag, "_full"},  32'(fifo_full), 32'd0);
        check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        check({tag, "_err"},   32'(err_cnt),   32'd0);
        check({tag, "_drop"},  32'(drop_cnt),  32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pt[$];
        int pc[$];
        int seen;
        int viol;
        logic [N_CMD-1:0] prev;

        // Reset values while rst is held low
        #3;
        check_reset_values("rst0");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        enable = 1'b1;
        model_reset();

        // Single command "3": first strobe right after release, pulse two cycles later
        send(8'h33);
        check("lat_c1_pulse", 32'(cmd_pulse), 32'd0);
        cyc();
        check("lat_c2_pulse", 32'(cmd_pulse), 32'b0000100);
        check("lat_c2_code",  32'(cmd_code),  32'd2);
        cyc();
        check("lat_c3_pulse", 32'(cmd_pulse), 32'd0);
        check("lat_c3_hold",  32'(cmd_hold),  32'b0000100);
        idle(4);
        check("lat_hold_kept", 32'(cmd_hold), 32'b0000100);

        // Out-of-range bytes
        send(8'h30);
        send(8'h38);
        send(8'h41);
        idle(3);
        check("inv_err",   32'(err_cnt),   32'd3);
        check("inv_empty", 32'(fifo_empty), 32'd1);

        // Fill while stalled: six bytes, four fit, two dropped
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(BASE_CHAR + 8'(i));
            if (i == 2) check("fill_not_full3", 32'(fifo_full), 32'd0);
            if (i == 3) check("fill_full4",     32'(fifo_full), 32'd1);
        end
        check("fill_drop", 32'(drop_cnt), 32'd2);
        enable = 1'b1;
        for (int t = 0; t < 24; t++) begin
            cyc();
            if (cmd_pulse != '0) begin
                pt.push_back(t);
                pc.push_back(int'(cmd_code));
            end
        end
        check("drain_count", 32'(pt.size()), 32'd4);
        if (pt.size() == 4) begin
            for (int k = 0; k < 4; k++) check("drain_order", 32'(pc[k]), 32'(k));
            for (int k = 1; k < 4; k++) check("drain_gap", 32'(pt[k] - pt[k-1]), 32'(GAP + 2));
        end

        // Reset during WAIT with two commands still queued
        enable = 1'b0;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        enable = 1'b1;
        seen = 0;
        for (int t = 0; t < 8 && seen == 0; t++) begin
            cyc();
            if (cmd_pulse != '0) seen = 1;
        end
        check("mid_pulse_seen", 32'(seen), 32'd1);
        cyc();                       // now in the first WAIT cycle
        check("mid_queued", 32'(exp_q.size()), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("rst_wait");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (cmd_pulse != '0) seen++;
        end
        check("post_rst_no_pulse", 32'(seen), 32'd0);
        check("post_rst_empty", 32'(fifo_empty), 32'd1);

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 3) == 0) rx_data = 8'($urandom_range(0, 255));
                else rx_data = BASE_CHAR + 8'($urandom_range(0, N_CMD));
                rx_ack = 1'b1;
            end else begin
                rx_ack  = 1'b0;
                rx_data = 8'($urandom_range(0, 255));
            end
            cyc();
        end
        rx_ack = 1'b0;
        enable = 1'b1;
        idle(30);

        // Error counter saturation
        for (int i = 0; i < 265; i++) send(8'h00);
        check("err_sat", 32'(err_cnt), 32'd255);

        // GAP=0 build: three queued bytes issue on alternate cycles
        enable2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_ack2  = 1'b1;
            rx_data2 = BASE_CHAR + 8'(i);
            cyc();
        end
        rx_ack2 = 1'b0;
        enable2 = 1'b1;
        pt.delete();
        pc.delete();
        viol = 0;
        prev = '0;
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (cmd_pulse2 != '0) begin
                pt.push_back(t);
                pc.push_back(int'(cmd_code2));
                if (prev != '0) viol++;
            end
            prev = cmd_pulse2;
        end
        check("g0_count", 32'(pt.size()), 32'd3);
        check("g0_no_consec", 32'(viol), 32'd0);
        if (pt.size() == 3) begin
            for (int k = 0; k < 3; k++) check("g0_order", 32'(pc[k]), 32'(k));
            for (int k = 1; k < 3; k++) check("g0_gap", 32'(pt[k] - pt[k-1]), 32'd2);
        end
        check("g0_idle_state", 32'(dbg_state2), 32'd0);
        check("g0_empty", 32'(fifo_empty2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/blt_cmd_queue.md
BLT_CMD_QUEUE -- requirements
Module: blt_cmd_queue

Interface
REQ-001 Parameter N_CMD, default 7: number of command channels, range 1..16.
REQ-002 Parameter BASE_CHAR, default 8'h31 ("1"): received byte mapped to command code 0.
REQ-003 Parameter CODE_W, default 3: command code width; 2^CODE_W >= N_CMD.
REQ-004 Parameter DEPTH, default 4: command FIFO depth; power of two, 2..64.
REQ-005 Parameter GAP, default 2: idle cycles enforced after each issued pulse; range 0..255.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 rst  input  1  reset; asynchronous, active-low.
REQ-008 rx_data  input  8  byte from the UART receiver; valid only while rx_ack is high.
REQ-009 rx_ack  input  1  one-cycle strobe: rx_data carries a new byte.
REQ-010 enable  input  1  high permits command issue; low stalls issue while the queue keeps filling.
REQ-011 cmd_pulse  output  N_CMD  one-hot, one-cycle command pulse.
REQ-012 cmd_code  output  CODE_W  code of the command currently or last issued.
REQ-013 cmd_hold  output  N_CMD  one-hot level of the last issued command; held until the next issue.
REQ-014 fifo_full, fifo_empty  output  1 each  queue status.
REQ-015 err_cnt  output  8  saturating count of bytes outside the command range.
REQ-016 drop_cnt  output  8  saturating count of valid bytes lost because the FIFO was full.

Function
REQ-017 On rx_ack high, the block SHALL compute the code as rx_data - BASE_CHAR (8-bit unsigned); the byte is valid iff rx_data >= BASE_CHAR and the code < N_CMD.
REQ-018 A valid byte SHALL be written to the FIFO on the rx_ack cycle edge if the FIFO is not full or a pop occurs on the same edge.
REQ-019 A valid byte SHALL otherwise be discarded, and drop_cnt SHALL increment, saturating at 255.
REQ-020 An invalid byte SHALL NOT enter the FIFO, and err_cnt SHALL increment, saturating at 255.
REQ-021 While rx_ack is low, the block SHALL ignore rx_data.
REQ-022 FIFO pointers SHALL be CODE_W-independent, log2(DEPTH)+1 bits wide, wrap modulo 2*DEPTH, and preserve order.
REQ-023 fifo_full and fifo_empty SHALL reflect the registered occupancy after each edge.
REQ-024 The issue FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-025 IDLE -> ISSUE when enable=1 and the FIFO is non-empty, popping the head on that edge.
REQ-026 ISSUE SHALL last exactly one cycle: cmd_pulse[code]=1, cmd_code=code, and cmd_hold is set to the one-hot of code.
REQ-027 ISSUE -> WAIT if GAP>0, otherwise ISSUE -> IDLE.
REQ-028 WAIT SHALL last exactly GAP cycles, counted by an 8-bit down-counter, then the FSM SHALL return to IDLE.
REQ-029 The minimum interval between consecutive pulse rising edges SHALL be GAP+2 cycles.
REQ-030 Latency: a valid byte written to an empty FIFO while the FSM is idle with enable=1 SHALL produce cmd_pulse in the second cycle after the rx_ack cycle.
REQ-031 Deasserting enable SHALL affect only the IDLE->ISSUE transition; ISSUE and WAIT SHALL complete normally.
REQ-032 At most one bit of cmd_pulse SHALL be high in any cycle, and cmd_pulse SHALL be all-zero outside ISSUE.
REQ-033 With the FIFO full, a simultaneous push and pop SHALL keep occupancy at DEPTH without incrementing drop_cnt.

Reset
REQ-034 While rst=0, the block SHALL asynchronously clear: state=IDLE, FIFO empty (fifo_empty=1, fifo_full=0), cmd_pulse=0, cmd_code=0, cmd_hold=0, err_cnt=0, drop_cnt=0, and the WAIT counter=0.
REQ-035 Reset asserted mid-ISSUE or mid-WAIT SHALL abort the FSM and flush all queued commands, with no pulse issued after release.
REQ-036 The block SHALL accept the first rx_ack on the first rising edge after rst deasserts.

Verification
REQ-037 Defaults, enable=1: single byte 8'h33 -> cmd_pulse=7'b0000100 for exactly one cycle, two cycles after rx_ack; cmd_code=2; cmd_hold=7'b0000100 thereafter.
REQ-038 Bytes 8'h30, 8'h38, 8'h41 -> no pulse, err_cnt=3, fifo_empty stays 1.
REQ-039 enable=0, then six valid bytes "1".."6" on consecutive strobes -> fifo_full after the 4th; drop_cnt=2. Raising enable afterwards -> pulses for codes 0,1,2,3 in order, rising edges 4 cycles apart.
REQ-040 GAP=0 build, three queued bytes -> pulses on alternate cycles (interval 2); cmd_pulse is never high on consecutive cycles.
REQ-041 rst pulsed low during WAIT with 2 entries queued -> all outputs reach their reset values immediately; no pulse follows release until a new byte arrives.
REQ-042 255 invalid bytes followed by 10 more -> err_cnt holds at 255.
